// File: rtl/dla_debug_network_pkg.sv
// Shared types and helpers for the debug-network head, nodes and ring top.
package dla_debug_network_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_DONE,
    ST_TIMEOUT
  } dbg_state_e;

  localparam int SPUR_CNT_W = 8;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dla_debug_network_timeout_counter.sv
// WAIT-phase cycle counter: clears on load, counts on enable, flags the last allowed cycle.
module dla_debug_network_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)    cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/dla_debug_network_head.sv
// Debug ring initiator: launches one read address into the ring and caches the
// response that comes back, with timeout and spurious-response accounting.
module dla_debug_network_head
  import dla_debug_network_pkg::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int ADDR_WIDTH     = 32,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int BUS_WIDTH      = max_w(ADDR_WIDTH, DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  i_aclr,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic                  i_resp_ack,
  output logic                  o_busy,
  output logic                  o_resp_valid,
  output logic [DATA_WIDTH-1:0] o_resp_data,
  output logic                  o_timeout,
  output logic [SPUR_CNT_W-1:0] o_spurious_count,
  output logic                  o_down_forced_valid,
  output logic [BUS_WIDTH-1:0]  o_down_shared_bus,
  output logic                  o_down_is_addr,
  input  logic                  i_up_forced_valid,
  input  logic [BUS_WIDTH-1:0]  i_up_shared_bus,
  input  logic                  i_up_is_addr
);

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst;

  always_ff @(posedge clk or posedge i_aclr) begin
    if (i_aclr) rst_sync_q <= 2'b11;
    else        rst_sync_q <= {rst_sync_q[0], 1'b0};
  end

  assign rst = rst_sync_q[1];

  dbg_state_e state_q, state_d;

  logic                  resp_valid_q, resp_valid_d;
  logic                  timeout_q, timeout_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic [BUS_WIDTH-1:0]  down_bus_q, down_bus_d;
  logic [SPUR_CNT_W-1:0] spur_q, spur_d;

  logic in_wait, resp_hit, capture, expire, ack_ok, tc;

  assign in_wait  = (state_q == ST_WAIT);
  // Returning addresses never count as responses.
  assign resp_hit = i_up_forced_valid & ~i_up_is_addr;
  assign capture  = resp_hit & in_wait & ~i_req_valid;
  assign expire   = in_wait & tc & ~resp_hit & ~i_req_valid;
  assign ack_ok   = i_resp_ack & ((state_q == ST_DONE) | (state_q == ST_TIMEOUT));

  dla_debug_network_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk   (clk),
    .rst_i (rst),
    .load_i(~in_wait),
    .en_i  (in_wait),
    .tc_o  (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_req_valid) begin
      state_d = ST_LAUNCH;
    end else begin
      unique case (state_q)
        ST_LAUNCH: state_d = ST_WAIT;
        ST_WAIT: begin
          if (capture)     state_d = ST_DONE;
          else if (expire) state_d = ST_TIMEOUT;
        end
        ST_DONE, ST_TIMEOUT: if (ack_ok) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy              = 1'b0;
    o_down_forced_valid = 1'b0;
    o_down_is_addr      = 1'b0;
    unique case (state_q)
      ST_LAUNCH: begin
        o_busy              = 1'b1;
        o_down_forced_valid = 1'b1;
        o_down_is_addr      = 1'b1;
      end
      ST_WAIT: o_busy = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    resp_valid_d = resp_valid_q;
    timeout_d    = timeout_q;
    resp_data_d  = resp_data_q;
    down_bus_d   = down_bus_q;
    spur_d       = spur_q;
    if (i_req_valid) begin
      resp_valid_d = 1'b0;
      timeout_d    = 1'b0;
      down_bus_d   = BUS_WIDTH'(i_req_addr);
    end else if (capture) begin
      resp_valid_d = 1'b1;
      resp_data_d  = i_up_shared_bus[DATA_WIDTH-1:0];
    end else if (expire) begin
      timeout_d = 1'b1;
    end else if (ack_ok) begin
      resp_valid_d = 1'b0;
      timeout_d    = 1'b0;
    end
    if (resp_hit && !capture && (spur_q != '1))
      spur_d = spur_q + SPUR_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      resp_data_q  <= '0;
      down_bus_q   <= '0;
      spur_q       <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      timeout_q    <= timeout_d;
      resp_data_q  <= resp_data_d;
      down_bus_q   <= down_bus_d;
      spur_q       <= spur_d;
    end
  end

  assign o_resp_valid      = resp_valid_q;
  assign o_timeout         = timeout_q;
  assign o_resp_data       = resp_data_q;
  assign o_down_shared_bus = down_bus_q;
  assign o_spurious_count  = spur_q;

endmodule

// File: doc/dla_debug_network_head.md
# dla_debug_network_head

Ring initiator for the debug network: accepts a single read request from the CSR block, injects the address into the debug ring at its upstream end, and captures the read-response data that circulates back from the last node. Holds the result in a status/data register the runtime polls. Fault tolerant: enforces a timeout, discards returning addresses and spurious or late responses, and never backpressures the ring.

## Interface
Parameters:
- DATA_WIDTH, 32, read response width
- ADDR_WIDTH, 32, read address width
- TIMEOUT_CYCLES, 1024, WAIT cycles before a request is declared timed out (≥2)
- BUS_WIDTH (localparam), max(ADDR_WIDTH, DATA_WIDTH), shared ring bus width

Ports:
- clk  in  1  clock
- i_aclr  in  1  reset; asynchronous, active-high
- i_req_valid  in  1  one-cycle pulse from CSR: launch read; never backpressured
- i_req_addr  in  ADDR_WIDTH  full address (upper bits select module id)
- i_resp_ack  in  1  CSR pulse: clear cached result/timeout, return to IDLE
- o_busy  out  1  request outstanding (LAUNCH or WAIT)
- o_resp_valid  out  1  response data cached
- o_resp_data  out  DATA_WIDTH  cached response data
- o_timeout  out  1  last request timed out
- o_spurious_count  out  8  saturating count of dropped responses
- o_down_forced_valid  out  1  to first ring node, non-backpressurable valid
- o_down_shared_bus  out  BUS_WIDTH  addr (zero-extended)
- o_down_is_addr  out  1  always 1 when o_down_forced_valid
- i_up_forced_valid  in  1  from last ring node
- i_up_shared_bus  in  BUS_WIDTH  returning addr/data
- i_up_is_addr  in  1  1 = returning address, 0 = response

## Operation
- States: IDLE, LAUNCH, WAIT, DONE, TIMEOUT.
- i_req_valid in any state: latch address, clear o_resp_valid/o_timeout, go to LAUNCH (clobbers any outstanding request).
- LAUNCH: drive o_down_forced_valid=1, o_down_is_addr=1, bus=address; next state WAIT, timeout counter=0.
- WAIT: counter increments each cycle; i_up_forced_valid & ~i_up_is_addr captures i_up_shared_bus[DATA_WIDTH-1:0] into o_resp_data, sets o_resp_valid, next DONE.
- WAIT with counter==TIMEOUT_CYCLES-1 and no response: next TIMEOUT, o_timeout=1.
- Returning address (i_up_is_addr=1): always dropped silently, any state.
- Response outside WAIT, or in the same cycle as i_req_valid: dropped, o_spurious_count +1 (saturates at 255).
- DONE/TIMEOUT: hold until i_resp_ack (-> IDLE, clear flags) or i_req_valid.
- Priority per cycle: i_req_valid > response capture > timeout > i_resp_ack.
- o_resp_data retains last value until next capture; not cleared by ack.

## Timing
- Reset (async assert, sync deassert internally): state IDLE, o_down_forced_valid=0, o_busy=0, o_resp_valid=0, o_timeout=0, o_spurious_count=0, o_resp_data=0, o_down_shared_bus=0, o_down_is_addr=0.
- i_req_valid at cycle N -> o_down_forced_valid high exactly cycle N+1 (one cycle), o_busy high N+1 until capture/timeout.
- Response on i_up at cycle M in WAIT -> o_resp_valid=1, o_busy=0 at M+1.
- No response: o_timeout=1 at N+2+TIMEOUT_CYCLES.
- Response on final WAIT cycle: response wins, o_timeout stays 0.
- All outputs registered; no combinational path i_up_* -> o_down_*.
- Reset mid-WAIT: outstanding request abandoned; later response counts as spurious.

## Structure
- dla_debug_network_pkg: state enum, BUS_WIDTH max function, spurious-count width constant; shared with node/ring top.
- Sub-module dla_debug_network_timeout_counter: load-to-zero, enable, terminal-count flag at TIMEOUT_CYCLES-1, width $clog2(TIMEOUT_CYCLES).

## Test plan
- Normal read: req addr 0x0300_0010 at cycle 10 -> down valid cycle 11 bus 0x0300_0010 is_addr=1; drive up data 0xDEADBEEF at cycle 20 -> o_resp_valid=1, data 0xDEADBEEF at 21; ack -> IDLE.
- Timeout, TIMEOUT_CYCLES=16: req at 10, no response -> o_timeout=1 at 28; late response at 40 -> o_spurious_count=1, o_resp_valid=0.
- Response on last WAIT cycle (27) -> o_resp_valid=1, o_timeout=0.
- Returning address (is_addr=1) during WAIT -> ignored, still WAIT, count unchanged.
- New request in WAIT with simultaneous response -> relaunch next cycle, count +1; 300 spurious responses -> count saturates 255.
- Assert i_aclr mid-WAIT -> all outputs to reset values immediately (asynchronous).
